// File: rtl/rx_pkg.sv
// rx_pkg: shared defaults for the rx event path (FIFO, synchronizer wrapper, bus interface)
package rx_pkg;
  localparam int RX_WIDTH = 8;
  localparam int RX_DEPTH_LOG2 = 3;
endpackage

// File: rtl/rx_event_fifo_mem.sv
// fifo_mem: register array with synchronous write and registered synchronous read
module fifo_mem
  import rx_pkg::*;
#(
  parameter int WIDTH = RX_WIDTH,
  parameter int ADDR_W = RX_DEPTH_LOG2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [WIDTH-1:0]  wrData,
  input  logic              rdEn,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic [WIDTH-1:0]  rdData
);
  logic [WIDTH-1:0] mem [2**ADDR_W];
  // storage is not reset; a read and a write to one entry in the same cycle return the old word
  always_ff @(posedge clk)
    if (wrEn) mem[wrAddr] <= wrData;
  // popped word is held until the next pop
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdData <= '0;
    else if (rdEn) rdData <= mem[rdAddr];
endmodule

// File: rtl/rx_event_fifo.sv
// rx_event_fifo: event-pulse FIFO with sticky overflow; irq built only with RX_EVENT_FIFO_IRQ_EN
module rx_event_fifo
  import rx_pkg::*;
#(
  parameter int WIDTH = RX_WIDTH,
  parameter int DEPTH_LOG2 = RX_DEPTH_LOG2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flag_in,
  input  logic [WIDTH-1:0]    data_in,
  input  logic                rd_en,
  output logic [WIDTH-1:0]    rd_data,
  output logic                rd_valid,
  output logic                empty,
  output logic                full,
  output logic [DEPTH_LOG2:0] count,
  output logic                overflow,
  input  logic                ovf_clr,
  output logic                irq
);
  localparam logic [DEPTH_LOG2-1:0] PtrOne = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0] CntOne = (DEPTH_LOG2 + 1)'(1);
  logic [DEPTH_LOG2-1:0] wrPtr, rdPtr;
  logic doPush, doPop, lostEvent;
  assign empty = count == '0;
  assign full = count[DEPTH_LOG2];
  assign doPop = rd_en && !empty;
  assign doPush = flag_in && (!full || doPop);
  assign lostEvent = flag_in && full && !doPop;
  // pointers wrap naturally; count tracks occupancy, overflow set wins over clear
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      rd_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PtrOne;
      if (doPop) rdPtr <= rdPtr + PtrOne;
      count <= (doPush && !doPop) ? count + CntOne : (doPop && !doPush) ? count - CntOne : count;
      rd_valid <= doPop;
      overflow <= lostEvent || (overflow && !ovf_clr);
    end
`ifdef RX_EVENT_FIFO_IRQ_EN
  // interrupt follows occupancy or a pending overflow, one cycle behind
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) irq <= 1'b0;
    else irq <= !empty || overflow;
`else
  assign irq = 1'b0;
`endif
  fifo_mem #(.WIDTH(WIDTH), .ADDR_W(DEPTH_LOG2)) uMem (
    .clk(clk),
    .rst_n(rst_n),
    .wrEn(doPush),
    .wrAddr(wrPtr),
    .wrData(data_in),
    .rdEn(doPop),
    .rdAddr(rdPtr),
    .rdData(rd_data)
  );
endmodule

// File: tb/tb_rx_event_fifo.sv
// tb_rx_event_fifo: directed and random stimulus checked against a queue model
module tb_rx_event_fifo;
  localparam int W = 8;
  localparam int DL = 3;
  localparam int DEPTH = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flag_in = 1'b0;
  logic rd_en = 1'b0;
  logic ovf_clr = 1'b0;
  logic [W-1:0] data_in = '0;
  logic [W-1:0] rd_data;
  logic rd_valid, empty, full, overflow, irq;
  logic [DL:0] count;
  int passCnt = 0;
  int totalCnt = 0;
  logic [W-1:0] q[$];
  logic [W-1:0] expData = '0;
  logic expValid = 1'b0;
  logic expOvf = 1'b0;
  logic expIrq = 1'b0;

  always #5 clk = ~clk;

  rx_event_fifo #(.WIDTH(W), .DEPTH_LOG2(DL)) dut (
    .clk(clk), .rst_n(rst_n), .flag_in(flag_in), .data_in(data_in), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty), .full(full), .count(count),
    .overflow(overflow), .ovf_clr(ovf_clr), .irq(irq)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalCnt++;
    if (got === exp) passCnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic checkAll(input string tag);
    checkVal({tag, ".count"}, 32'(count), 32'(q.size()));
    checkVal({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    checkVal({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
    checkVal({tag, ".overflow"}, 32'(overflow), 32'(expOvf));
    checkVal({tag, ".rd_valid"}, 32'(rd_valid), 32'(expValid));
    checkVal({tag, ".rd_data"}, 32'(rd_data), 32'(expData));
    checkVal({tag, ".irq"}, 32'(irq), 32'(expIrq));
  endtask

  // one clock: drive at negedge, update the model at the edge, compare shortly after
  task automatic cycle(input string tag, input logic f, input logic [W-1:0] d, input logic r, input logic c);
    bit wasFull, wasEmpty, pop, push;
    @(negedge clk);
    flag_in = f;
    data_in = d;
    rd_en = r;
    ovf_clr = c;
    @(posedge clk);
    wasFull = q.size() == DEPTH;
    wasEmpty = q.size() == 0;
`ifdef RX_EVENT_FIFO_IRQ_EN
    expIrq = !wasEmpty || expOvf;
`else
    expIrq = 1'b0;
`endif
    pop = r && !wasEmpty;
    push = f && (!wasFull || pop);
    expValid = pop;
    if (pop) expData = q.pop_front();
    if (push) q.push_back(d);
    if (f && wasFull && !pop) expOvf = 1'b1;
    else if (c) expOvf = 1'b0;
    #1 checkAll(tag);
  endtask

  // asynchronous reset asserted between edges, checked before any edge arrives
  task automatic doReset();
    @(negedge clk);
    flag_in = 1'b0;
    rd_en = 1'b0;
    ovf_clr = 1'b0;
    #2 rst_n = 1'b0;
    q.delete();
    expData = '0;
    expValid = 1'b0;
    expOvf = 1'b0;
    expIrq = 1'b0;
    #1 checkAll("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    doReset();
    cycle("a5", 1'b1, 8'hA5, 1'b0, 1'b0);
    cycle("3c", 1'b1, 8'h3C, 1'b0, 1'b0);
    cycle("rd1", 1'b0, 8'h00, 1'b1, 1'b0);
    checkVal("rdA5", 32'(rd_data), 32'h0A5);
    cycle("rd2", 1'b0, 8'h00, 1'b1, 1'b0);
    checkVal("rd3C", 32'(rd_data), 32'h03C);
    checkVal("emptyAfter", 32'(empty), 32'd1);
    cycle("rdEmpty", 1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) cycle("fill9", 1'b1, W'(8'h10 + i), 1'b0, 1'b0);
    checkVal("ovfAfter9", 32'(overflow), 32'd1);
    checkVal("cntAfter9", 32'(count), 32'd8);
    for (int i = 0; i < 8; i++) begin
      cycle("drain8", 1'b0, 8'h00, 1'b1, 1'b0);
      checkVal("order", 32'(rd_data), 32'(8'h10 + i));
    end
    cycle("clrOvf", 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) cycle("fill8", 1'b1, W'(8'h20 + i), 1'b0, 1'b0);
    cycle("fullRw", 1'b1, 8'h77, 1'b1, 1'b0);
    checkVal("fullRwCnt", 32'(count), 32'd8);
    checkVal("fullRwOvf", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) cycle("drainRw", 1'b0, 8'h00, 1'b1, 1'b0);
    checkVal("lastWord", 32'(rd_data), 32'h077);
    cycle("emptyRw", 1'b1, 8'h55, 1'b1, 1'b0);
    checkVal("emptyRwValid", 32'(rd_valid), 32'd0);
    cycle("popRw", 1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cycle("pairPush", 1'b1, W'(8'h40 + i), 1'b0, 1'b0);
      cycle("pairPop", 1'b0, 8'h00, 1'b1, 1'b0);
      checkVal("pairData", 32'(rd_data), 32'(8'h40 + i));
    end
    for (int i = 0; i < 5; i++) cycle("pre5", 1'b1, W'(8'h60 + i), 1'b0, 1'b0);
    doReset();
    cycle("postPush", 1'b1, 8'h99, 1'b0, 1'b0);
    cycle("postPop", 1'b0, 8'h00, 1'b1, 1'b0);
    checkVal("postData", 32'(rd_data), 32'h099);
    for (int i = 0; i < 400; i++)
      cycle("rand", 1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 7) == 0));
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule

// File: doc/rx_event_fifo.md
RX_EVENT_FIFO -- requirements
Module: rx_event_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits.
REQ-002 SHALL have parameter DEPTH_LOG2, default 3: FIFO depth is 2**DEPTH_LOG2 entries.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port flag_in, input, 1 bit: one-cycle event pulse, already synchronized into clk by the upstream flag synchronizer.
REQ-006 SHALL have port data_in, input, WIDTH bits: payload held quasi-static by the source domain, valid whenever flag_in is high.
REQ-007 SHALL have port rd_en, input, 1 bit: pop request from the consumer.
REQ-008 SHALL have port rd_data, output, WIDTH bits: registered popped word.
REQ-009 SHALL have port rd_valid, output, 1 bit: high for one cycle when rd_data holds a newly popped word.
REQ-010 SHALL have port empty, output, 1 bit: high when count = 0.
REQ-011 SHALL have port full, output, 1 bit: high when count = 2**DEPTH_LOG2.
REQ-012 SHALL have port count, output, DEPTH_LOG2+1 bits: current occupancy.
REQ-013 SHALL have port overflow, output, 1 bit: sticky lost-event flag.
REQ-014 SHALL have port ovf_clr, input, 1 bit: clears overflow.
REQ-015 SHALL have port irq, output, 1 bit: level interrupt request (see Configuration).

Function
REQ-016 SHALL push data_in into the FIFO in the same cycle that flag_in = 1 and full = 0.
REQ-017 SHALL pop on rd_en = 1 with empty = 0; rd_data and rd_valid SHALL update on the next edge (1-cycle latency).
REQ-018 SHALL ignore rd_en when empty = 1; rd_data holds its value and rd_valid = 0.
REQ-019 SHALL, with flag_in = 1 and full = 1 and rd_en = 0, drop the word and set overflow on the next edge.
REQ-020 SHALL, with flag_in = 1, rd_en = 1 and full = 1, perform both pop and push; count stays full and overflow stays unchanged.
REQ-021 SHALL, with flag_in = 1, rd_en = 1 and empty = 1, push only; count becomes 1 and rd_valid = 0, with no bypass.
REQ-022 SHALL keep write and read pointers of DEPTH_LOG2 bits that wrap modulo 2**DEPTH_LOG2; count SHALL be a separate DEPTH_LOG2+1-bit counter.
REQ-023 SHALL give set priority over clear when ovf_clr and an overflow event occur in the same cycle, so overflow stays 1.
REQ-024 SHALL preserve first-in first-out order across pointer wrap-around.

Reset
REQ-025 SHALL, while rst_n = 0, immediately clear pointers, count, overflow, rd_valid, irq and rd_data to 0; empty = 1 and full = 0.
REQ-026 SHALL discard stored contents on reset mid-operation; the first push after rst_n rises SHALL land in entry 0.
REQ-027 SHALL NOT require storage array contents to be reset.

Configuration
REQ-028 SHALL, with macro RX_EVENT_FIFO_IRQ_EN defined, register irq each cycle as the value (empty = 0) OR (overflow = 1).
REQ-029 SHALL, without RX_EVENT_FIFO_IRQ_EN, tie irq to constant 0 and build no irq register.

Structure
REQ-030 SHALL place the default WIDTH and DEPTH_LOG2 constants in the shared package rx_pkg, for reuse by the synchronizer wrapper and the bus interface.
REQ-031 SHALL put the storage array in one sub-module, fifo_mem: a synchronous-write, synchronous-read register array; pointer and count logic stay in rx_event_fifo.

Verification
REQ-032 SHALL cover: flag_in pulses with data_in = 8'hA5 then 8'h3C, then rd_en twice -> rd_data = A5 then 3C, each one cycle after rd_en, and empty = 1 afterwards.
REQ-033 SHALL cover: 9 pulses with DEPTH_LOG2 = 3 and no reads -> full = 1, count = 8, overflow = 1 after the 9th, then 8 reads return the first 8 words in order.
REQ-034 SHALL cover: FIFO full, flag_in and rd_en in the same cycle -> count stays 8, overflow stays 0, and the new word appears last.
REQ-035 SHALL cover: 20 interleaved push/pop pairs -> pointers wrap twice, no data loss, count never exceeds 1.
REQ-036 SHALL cover: rst_n pulsed low with count = 5 -> all outputs go to their reset values with no clock edge, and the next push/pop returns the new word.
REQ-037 SHALL cover: with RX_EVENT_FIFO_IRQ_EN, one push -> irq = 1 on the following edge; pop -> irq = 0; without the macro, irq = 0 throughout.
